id_ex_stage: RTL and testbench

- ID→EX pipeline stage directly downstream of the ID-stage register file.
- Takes the register-file read data (ReadData1/ReadData2) plus decoded fields, and applies the WB→ID same-cycle bypass. The register file writes on posedge and reads combinationally, so a write in the current cycle is not yet visible.
- Generates the immediate, detects load-use hazards (inserting bubbles), and holds a valid/ready-handshaked ID/EX register with flush support and a saturating stall counter.

---
 rtl/id_ex_stage.sv | 155 +++++++++++++++
 tb/tb_id_ex_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with WB->ID bypass, immediate
// generation, load-use hazard detection and a saturating bubble counter.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_valid / id_ready      ID-side handshake (id_ready is combinational)
//   id_pc, id_instr          ID instruction and its PC
//   id_mem_read              ID instruction is a load
//   ReadData1, ReadData2     register-file read data for rs1 / rs2
//   wb_RegWrite, wb_rd,
//   wb_data                  same-cycle WB write (not yet visible in the RF)
//   flush                    redirect: kill ID and EX contents
//   ex_ready / ex_valid      EX-side handshake
//   ex_*                     registered operands, fields and load flag
//   stall_count              saturating count of load-use bubbles
module id_ex_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [XLEN-1:0]        id_pc,
    input  logic [31:0]            id_instr,
    input  logic                   id_mem_read,
    input  logic [XLEN-1:0]        ReadData1,
    input  logic [XLEN-1:0]        ReadData2,
    input  logic                   wb_RegWrite,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   flush,
    input  logic                   ex_ready,
    output logic                   ex_valid,
    output logic [XLEN-1:0]        ex_pc,
    output logic [XLEN-1:0]        ex_rs1_data,
    output logic [XLEN-1:0]        ex_rs2_data,
    output logic [XLEN-1:0]        ex_imm,
    output logic [31:0]            ex_instr,
    output logic [4:0]             ex_rd,
    output logic [4:0]             ex_rs1,
    output logic [4:0]             ex_rs2,
    output logic                   ex_mem_read,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] imm;
    logic            hazard;
    logic            adv;

    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign rd     = id_instr[11:7];
    assign opcode = id_instr[6:0];

    // WB->ID bypass; x0 reads as zero so a matching wb_rd of 0 can never hit
    always_comb begin
        src1 = ReadData1;
        src2 = ReadData2;
        if (rs1 == 5'd0) begin
            src1 = '0;
        end else if (wb_RegWrite && (wb_rd == rs1)) begin
            src1 = wb_data;
        end
        if (rs2 == 5'd0) begin
            src2 = '0;
        end else if (wb_RegWrite && (wb_rd == rs2)) begin
            src2 = wb_data;
        end
    end

    // Immediate generation, sign-extended from bit 31 of the instruction
    always_comb begin
        imm = '0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR:
                imm = XLEN'($signed(id_instr[31:20]));
            OP_STORE:
                imm = XLEN'($signed({id_instr[31:25], id_instr[11:7]}));
            OP_BRANCH:
                imm = XLEN'($signed({id_instr[31], id_instr[7], id_instr[30:25],
                                     id_instr[11:8], 1'b0}));
            OP_LUI, OP_AUIPC:
                imm = XLEN'($signed({id_instr[31:12], 12'b0}));
            OP_JAL:
                imm = XLEN'($signed({id_instr[31], id_instr[19:12], id_instr[20],
                                     id_instr[30:21], 1'b0}));
            default:
                imm = '0;
        endcase
    end

    // Load-use check against the load sitting in ID/EX (both rs fields, always)
    assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == rs1) || (ex_rd == rs2));
    assign adv      = !ex_valid || ex_ready;
    assign id_ready = flush || (adv && !hazard);

    // ID/EX register and bubble counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_instr    <= '0;
            ex_rd       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_mem_read <= 1'b0;
            stall_count <= '0;
        end else begin
            if (hazard && adv && !flush && (stall_count != STALL_MAX)) begin
                stall_count <= stall_count + STALL_CNT_W'(1);
            end
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (adv) begin
                if (id_valid && !hazard) begin
                    ex_valid    <= 1'b1;
                    ex_pc       <= id_pc;
                    ex_rs1_data <= src1;
                    ex_rs2_data <= src2;
                    ex_imm      <= imm;
                    ex_instr    <= id_instr;
                    ex_rd       <= rd;
                    ex_rs1      <= rs1;
                    ex_rs2      <= rs2;
                    ex_mem_read <= id_mem_read;
                end else begin
                    ex_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: vector table, directed multi-cycle sequences and
// randomized traffic, all checked against a behavioural model.
module tb_id_ex_stage;

    localparam int unsigned XLEN  = 32;
    // Narrow counter so saturation is reachable in a short run
    localparam int unsigned CNT_W = 8;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic             id_ready;
    logic [XLEN-1:0]  id_pc;
    logic [31:0]      id_instr;
    logic             id_mem_read;
    logic [XLEN-1:0]  ReadData1;
    logic [XLEN-1:0]  ReadData2;
    logic             wb_RegWrite;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             flush;
    logic             ex_ready;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic [XLEN-1:0]  ex_imm;
    logic [31:0]      ex_instr;
    logic [4:0]       ex_rd;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic             ex_mem_read;
    logic [CNT_W-1:0] stall_count;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .STALL_CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_instr(id_instr), .id_mem_read(id_mem_read),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_instr(ex_instr), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_mem_read(ex_mem_read), .stall_count(stall_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: contents of the ID/EX slot
    logic        mValid = 1'b0;
    logic        mMem = 1'b0;
    logic [31:0] mPc, mInstr, mRs1d, mRs2d, mImm;
    logic [4:0]  mRd = '0;
    logic [4:0]  mRs1, mRs2;
    int unsigned mCnt = 0;

    // Immediate from the ISA bit layouts, assembled with arithmetic
    function automatic logic [31:0] refImm(input logic [31:0] ins);
        logic [31:0] s;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: return 32'($signed(ins) >>> 20);
            7'h23: return (32'($signed(ins) >>> 20) & 32'hFFFF_FFE0) | 32'(ins[11:7]);
            7'h63: begin
                s = ins[31] ? 32'hFFFF_F000 : 32'h0;
                return s + (32'(ins[7]) << 11) + (32'(ins[30:25]) << 5) + (32'(ins[11:8]) << 1);
            end
            7'h37, 7'h17: return ins & 32'hFFFF_F000;
            7'h6F: begin
                s = ins[31] ? 32'hFFF0_0000 : 32'h0;
                return s + (32'(ins[19:12]) << 12) + (32'(ins[20]) << 11) + (32'(ins[30:21]) << 1);
            end
            default: return 32'h0;
        endcase
    endfunction

    // Register read as the pipeline should see it, including the pending WB
    function automatic logic [31:0] refSrc(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'h0;
        if (wb_RegWrite && wb_rd == r) return wb_data;
        return rf;
    endfunction

    // One clock: check id_ready, advance the model, then check the register
    task automatic tick();
        logic [4:0] r1, r2;
        logic hz, adv, expReady;
        #1;
        r1 = id_instr[19:15];
        r2 = id_instr[24:20];
        hz = id_valid && mValid && mMem && mRd != 5'd0 && (mRd == r1 || mRd == r2);
        adv = !mValid || ex_ready;
        expReady = flush || (adv && !hz);
        if (!rst) chk("id_ready", 64'(id_ready), 64'(expReady));
        if (rst) begin
            mValid = 0; mMem = 0; mPc = 0; mInstr = 0; mRs1d = 0; mRs2d = 0;
            mImm = 0; mRd = 0; mRs1 = 0; mRs2 = 0; mCnt = 0;
        end else begin
            if (hz && adv && !flush && mCnt < CNT_MAX) mCnt++;
            if (flush) mValid = 0;
            else if (adv) begin
                if (id_valid && !hz) begin
                    mValid = 1; mMem = id_mem_read; mPc = id_pc; mInstr = id_instr;
                    mRs1d = refSrc(r1, ReadData1); mRs2d = refSrc(r2, ReadData2);
                    mImm = refImm(id_instr); mRd = id_instr[11:7]; mRs1 = r1; mRs2 = r2;
                end else mValid = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("ex_valid", 64'(ex_valid), 64'(mValid));
        chk("stall_count", 64'(stall_count), 64'(mCnt));
        if (mValid) begin
            chk("ex_pc", 64'(ex_pc), 64'(mPc));
            chk("ex_instr", 64'(ex_instr), 64'(mInstr));
            chk("ex_rs1_data", 64'(ex_rs1_data), 64'(mRs1d));
            chk("ex_rs2_data", 64'(ex_rs2_data), 64'(mRs2d));
            chk("ex_imm", 64'(ex_imm), 64'(mImm));
            chk("ex_rd", 64'(ex_rd), 64'(mRd));
            chk("ex_rs1", 64'(ex_rs1), 64'(mRs1));
            chk("ex_rs2", 64'(ex_rs2), 64'(mRs2));
            chk("ex_mem_read", 64'(ex_mem_read), 64'(mMem));
        end
    endtask

    task automatic setId(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic mem);
        id_valid = v; id_pc = pc; id_instr = ins; id_mem_read = mem;
    endtask

    task automatic setRf(input logic [31:0] d1, input logic [31:0] d2, input logic we,
                         input logic [4:0] wrd, input logic [31:0] wd);
        ReadData1 = d1; ReadData2 = d2; wb_RegWrite = we; wb_rd = wrd; wb_data = wd;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        mem;
        logic [31:0] rd1, rd2;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [31:0] eRs1d, eRs2d, eImm;
        logic [4:0]  eRd;
    } vec_t;

    vec_t vecs[12];

    localparam logic [31:0] LW_X7  = 32'h0000A383;  // lw  x7,0(x1)
    localparam logic [31:0] ADD_X8 = 32'h00238433;  // add x8,x7,x2
    localparam logic [31:0] ADDI_A = 32'h00518213;  // addi x4,x3,5
    localparam logic [31:0] LW_7_7 = 32'h0003A383;  // lw  x7,0(x7)

    logic [6:0] opList[10];

    initial begin
        vecs[0]  = '{32'h00518213, 0, 32'h11, 32'h22, 1, 5'd3,  32'hABCD, 32'hABCD, 32'h22, 32'h5, 5'd4};
        vecs[1]  = '{32'h00518213, 0, 32'h11, 32'h22, 1, 5'd0,  32'hABCD, 32'h11, 32'h22, 32'h5, 5'd4};
        vecs[2]  = '{32'h00500213, 0, 32'h11, 32'h22, 1, 5'd3,  32'hABCD, 32'h0, 32'h22, 32'h5, 5'd4};
        vecs[3]  = '{32'h00238433, 0, 32'h77, 32'h99, 1, 5'd2,  32'h5555, 32'h77, 32'h5555, 32'h0, 5'd8};
        vecs[4]  = '{32'h0020A423, 0, 32'h10, 32'h20, 0, 5'd1,  32'h1, 32'h10, 32'h20, 32'h8, 5'd8};
        vecs[5]  = '{32'hFE20AE23, 0, 32'h10, 32'h20, 1, 5'd1,  32'h3333, 32'h3333, 32'h20, 32'hFFFFFFFC, 5'd28};
        vecs[6]  = '{32'h123452B7, 0, 32'h44, 32'h55, 0, 5'd0,  32'h0, 32'h44, 32'h55, 32'h12345000, 5'd5};
        vecs[7]  = '{32'h008000EF, 0, 32'h66, 32'h88, 0, 5'd0,  32'h0, 32'h0, 32'h88, 32'h8, 5'd1};
        vecs[8]  = '{32'hFFFFFFFF, 0, 32'h1, 32'h2, 1, 5'd31, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'h0, 5'd31};
        vecs[9]  = '{32'hFFFFF197, 0, 32'hA, 32'hB, 0, 5'd0,  32'h0, 32'hA, 32'hB, 32'hFFFFF000, 5'd3};
        vecs[10] = '{32'hFF0280E7, 0, 32'h5, 32'h6, 1, 5'd5,  32'h7777, 32'h7777, 32'h6, 32'hFFFFFFF0, 5'd1};
        vecs[11] = '{32'h00412303, 1, 32'h12, 32'h34, 0, 5'd0, 32'h0, 32'h12, 32'h34, 32'h4, 5'd6};
        opList = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

        // Reset with a valid instruction presented
        rst = 1; flush = 0; ex_ready = 1;
        setId(1, 32'h100, 32'hFFF08293, 0);
        setRf(32'h0, 32'h0, 0, 5'd0, 32'h0);
        tick(); tick();
        chk("rst_ex_valid", 64'(ex_valid), 64'h0);
        chk("rst_ex_pc", 64'(ex_pc), 64'h0);
        chk("rst_ex_imm", 64'(ex_imm), 64'h0);
        chk("rst_ex_instr", 64'(ex_instr), 64'h0);
        chk("rst_stall", 64'(stall_count), 64'h0);

        // First instruction after reset: addi x5,x1,-1
        rst = 0;
        tick();
        chk("addi_valid", 64'(ex_valid), 64'h1);
        chk("addi_imm", 64'(ex_imm), 64'hFFFFFFFF);
        chk("addi_rd", 64'(ex_rd), 64'h5);

        // Vector table: bypass and immediate formats
        for (int i = 0; i < 12; i++) begin
            setId(1, 32'h1000 + 32'(i * 4), vecs[i].instr, vecs[i].mem);
            setRf(vecs[i].rd1, vecs[i].rd2, vecs[i].we, vecs[i].wrd, vecs[i].wdata);
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(ex_valid), 64'h1);
            chk($sformatf("vec%0d_rs1d", i), 64'(ex_rs1_data), 64'(vecs[i].eRs1d));
            chk($sformatf("vec%0d_rs2d", i), 64'(ex_rs2_data), 64'(vecs[i].eRs2d));
            chk($sformatf("vec%0d_imm", i), 64'(ex_imm), 64'(vecs[i].eImm));
            chk($sformatf("vec%0d_rd", i), 64'(ex_rd), 64'(vecs[i].eRd));
        end
        setRf(32'h0, 32'h0, 0, 5'd0, 32'h0);

        // Load-use: exactly one bubble, then the dependent add is taken
        setId(1, 32'h2000, LW_X7, 1);
        tick();
        setId(1, 32'h2004, ADD_X8, 0);
        #1 chk("lu_id_ready", 64'(id_ready), 64'h0);
        tick();
        chk("lu_bubble", 64'(ex_valid), 64'h0);
        chk("lu_stall", 64'(stall_count), 64'h1);
        tick();
        chk("lu_accept", 64'(ex_valid), 64'h1);
        chk("lu_instr", 64'(ex_instr), 64'(ADD_X8));

        // Downstream stall: hold for 3 cycles, load on release
        setId(1, 32'h2008, ADDI_A, 0);
        ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_id_ready", 64'(id_ready), 64'h0);
            tick();
            chk("bp_hold_instr", 64'(ex_instr), 64'(ADD_X8));
            chk("bp_hold_pc", 64'(ex_pc), 64'h2004);
        end
        ex_ready = 1;
        tick();
        chk("bp_release", 64'(ex_instr), 64'(ADDI_A));

        // Flush with EX stalled and a hazard present
        setId(1, 32'h3000, LW_X7, 1);
        tick();
        setId(1, 32'h3004, ADD_X8, 0);
        ex_ready = 0; flush = 1;
        #1 chk("fl_id_ready", 64'(id_ready), 64'h1);
        tick();
        chk("fl_valid", 64'(ex_valid), 64'h0);
        chk("fl_stall", 64'(stall_count), 64'h1);
        flush = 0; ex_ready = 1;

        // Self-dependent load repeatedly bubbles: drive the counter to saturation
        setId(1, 32'h4000, LW_7_7, 1);
        for (int i = 0; i < 2 * CNT_MAX + 40; i++) tick();
        chk("sat_stall", 64'(stall_count), 64'(CNT_MAX));

        // beq offset -4
        setId(1, 32'h4100, 32'hFE000EE3, 0);
        tick();
        chk("beq_imm", 64'(ex_imm), 64'hFFFFFFFC);
        chk("sat_hold", 64'(stall_count), 64'(CNT_MAX));

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] ins;
            logic [4:0]  regs[4];
            regs = '{5'd0, 5'd1, 5'd2, 5'd7};
            ins = $urandom;
            ins[6:0]   = opList[$urandom_range(0, 9)];
            ins[19:15] = regs[$urandom_range(0, 3)];
            ins[24:20] = regs[$urandom_range(0, 3)];
            ins[11:7]  = regs[$urandom_range(0, 3)];
            rst      = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            ex_ready = ($urandom_range(0, 9) < 7);
            setId($urandom_range(0, 9) < 8, $urandom, ins,
                  (ins[6:0] == 7'h03) || ($urandom_range(0, 7) == 0));
            setRf($urandom, $urandom, 1'($urandom), regs[$urandom_range(0, 3)], $urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
